// File: rtl/load_store_unit_if.sv
// Access-size type shared by the load/store unit and its users, plus the
// word-wide data-memory bus carrying the req/ready/rvalid handshake.
package load_store_unit_pkg;
  typedef enum logic [1:0] {
    MEM_BYTE     = 2'b00,
    MEM_HALFWORD = 2'b01,
    MEM_WORD     = 2'b10
  } memory_mask_t;
endpackage

interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory side of loads/stores: one bus transaction per start, with lane
// steering, load extension, misalignment detection and a bounded bus wait.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_load_memory,
  input  logic                    i_store_memory,
  input  memory_mask_t            i_memory_mask,
  input  logic                    i_memory_sign_extension,
  input  logic [31:0]             i_address,
  input  logic [31:0]             i_store_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [31:0]             o_load_data,
  output logic                    o_misaligned,
  output logic                    o_timeout,
  load_store_unit_if.master       mem
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  function automatic logic [3:0] f_byte_en(input memory_mask_t m, input logic [1:0] a);
    case (m)
      MEM_BYTE:     return 4'b0001 << a;
      MEM_HALFWORD: return a[1] ? 4'b1100 : 4'b0011;
      default:      return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input memory_mask_t m, input logic [31:0] d);
    case (m)
      MEM_BYTE:     return {4{d[7:0]}};
      MEM_HALFWORD: return {2{d[15:0]}};
      default:      return d;
    endcase
  endfunction

  function automatic logic f_misaligned(input memory_mask_t m, input logic [1:0] a);
    case (m)
      MEM_BYTE:     return 1'b0;
      MEM_HALFWORD: return a[0];
      default:      return (a != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] f_extract(input memory_mask_t m, input logic [1:0] a,
                                            input logic sx, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = rd[{a[1], 4'b0000} +: 16];
    case (m)
      MEM_BYTE:     return sx ? {{24{b[7]}}, b} : {24'h000000, b};
      MEM_HALFWORD: return sx ? {{16{h[15]}}, h} : {16'h0000, h};
      default:      return rd;
    endcase
  endfunction

  state_t       r_state, w_next_state;
  logic [CW-1:0] r_cnt;
  logic          r_is_store, r_sign;
  memory_mask_t  r_mask;
  logic [1:0]    r_addr_lo;
  logic          r_busy, r_done, r_misaligned, r_timeout, r_mem_req, r_mem_we;
  logic [31:0]   r_load_data, r_mem_addr, r_mem_wdata;
  logic [3:0]    r_mem_be;
  logic          w_launch, w_misaligned, w_timeout, w_capture, w_last;

  // The final allowed REQ/WAIT cycle: anything short of completion here aborts.
  assign w_last = (r_cnt == CW'(MAX_WAIT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode and per-cycle event strobes.
  always_comb begin
    w_next_state = r_state;
    w_launch     = 1'b0;
    w_misaligned = 1'b0;
    w_timeout    = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_start) begin
          w_next_state = S_IDLE;
        end else if (!i_store_memory && !i_load_memory) begin
          w_next_state = S_RESP;
        end else if (f_misaligned(i_memory_mask, i_address[1:0])) begin
          w_next_state = S_RESP;
          w_misaligned = 1'b1;
        end else begin
          w_next_state = S_REQ;
          w_launch     = 1'b1;
        end
      end
      S_REQ: begin
        // A load accepted on the last allowed cycle still has no data, so it aborts.
        if (mem.mem_ready && r_is_store) begin
          w_next_state = S_RESP;
        end else if (w_last) begin
          w_next_state = S_RESP;
          w_timeout    = 1'b1;
        end else if (mem.mem_ready) begin
          w_next_state = S_WAIT;
        end else begin
          w_next_state = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem.mem_rvalid) begin
          w_next_state = S_RESP;
          w_capture    = 1'b1;
        end else if (w_last) begin
          w_next_state = S_RESP;
          w_timeout    = 1'b1;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the next state, plus transaction latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_is_store   <= 1'b0;
      r_sign       <= 1'b0;
      r_mask       <= MEM_BYTE;
      r_addr_lo    <= 2'b00;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0000_0000;
      r_mem_wdata  <= 32'h0000_0000;
      r_mem_be     <= 4'b0000;
      r_load_data  <= 32'h0000_0000;
    end else begin
      r_busy       <= (w_next_state != S_IDLE);
      r_done       <= (w_next_state == S_RESP);
      r_mem_req    <= (w_next_state == S_REQ);
      r_misaligned <= w_misaligned;
      r_timeout    <= w_timeout;
      if (w_launch) begin
        r_cnt       <= '0;
        r_is_store  <= i_store_memory;
        r_sign      <= i_memory_sign_extension;
        r_mask      <= i_memory_mask;
        r_addr_lo   <= i_address[1:0];
        r_mem_we    <= i_store_memory;
        r_mem_addr  <= {i_address[31:2], 2'b00};
        r_mem_be    <= f_byte_en(i_memory_mask, i_address[1:0]);
        r_mem_wdata <= f_wdata(i_memory_mask, i_store_data);
      end else if (r_state == S_REQ || r_state == S_WAIT) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_capture) begin
        r_load_data <= f_extract(r_mask, r_addr_lo, r_sign, mem.mem_rdata);
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_load_data   = r_load_data;
  assign o_misaligned  = r_misaligned;
  assign o_timeout     = r_timeout;
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign mem.mem_be    = r_mem_be;
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Executes the data-memory side of loads and stores marked by the instruction decoder's load_memory / store_memory / memory_mask / memory_sign_extension outputs.
- Takes a byte address and store data from the datapath and runs one transaction on a word-wide data-memory bus using a req/ready/rvalid handshake.
- Returns aligned, sign- or zero-extended load data to the register-file write path, with a one-cycle completion pulse.

Parameters:
MAX_WAIT, 255, bus cycles allowed in REQ+WAIT before the transaction is aborted with timeout (must be >= 2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  launch a transaction; sampled only in IDLE
load_memory  input  1  transaction is a load
store_memory  input  1  transaction is a store
memory_mask  input  memory_mask_t  MEM_BYTE / MEM_HALFWORD / MEM_WORD access size
memory_sign_extension  input  1  load result is sign-extended (ignored for word and stores)
address  input  32  byte address
store_data  input  32  rs2 value; low bits used for byte/halfword
busy  output  1  transaction in progress
done  output  1  one-cycle completion pulse
load_data  output  32  extended load result; valid with done, held until next completed load
misaligned  output  1  valid with done; access was misaligned, no bus traffic
timeout  output  1  valid with done; bus did not respond within MAX_WAIT
mem_req  output  1  bus request
mem_we  output  1  1 = write
mem_addr  output  32  word address {address[31:2],2'b00}
mem_wdata  output  32  lane-replicated write data
mem_be  output  4  byte enables
mem_ready  input  1  bus accepts the request this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read data word

Behaviour:
- States: IDLE, REQ, WAIT, RESP.
- Reset: state IDLE. busy, done, misaligned, timeout, mem_req, mem_we, mem_be, mem_addr, mem_wdata, load_data, and wait counter are all 0.
- Reset mid-transaction: mem_req low from the next cycle. A later mem_rvalid is ignored.
- IDLE + start: latch all inputs.
  - store_memory=1 is a store (store wins if both are set). load_memory=1 alone is a load.
  - Neither set: go to RESP, no bus traffic, no flags, load_data unchanged.
  - Misaligned (halfword with addr[0]=1, or word with addr[1:0]!=0): go to RESP with misaligned=1, no bus traffic.
  - Otherwise: go to REQ and clear the counter.
- start outside IDLE is ignored.
- REQ: mem_req=1. mem_we, mem_addr, mem_wdata, mem_be are stable until accepted.
  - mem_ready=1 with a store: go to RESP.
  - mem_ready=1 with a load: go to WAIT.
- WAIT: mem_req=0. mem_rvalid is sampled only here, earliest the cycle after acceptance. On mem_rvalid: register the extended data into load_data and go to RESP.
- Timeout: counter increments each REQ/WAIT cycle that does not complete. If MAX_WAIT cycles elapse without completion, go to RESP with timeout=1. load_data is unchanged and mem_req drops.
- RESP: done=1 for exactly one cycle, flags valid, then IDLE.
- busy=1 in REQ, WAIT, RESP.
- Latency: store with immediate ready gives done 2 cycles after start. Load with immediate ready and rvalid on the next cycle gives done 3 cycles after start. Misaligned or no-op gives done 1 cycle after start.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
- Write data: byte = store_data[7:0] replicated x4; half = store_data[15:0] replicated x2; word unchanged.
- Load extraction:
  - byte = mem_rdata[8*addr[1:0] +: 8]
  - half = mem_rdata[16*addr[1] +: 16]
  - Extend with the sign bit if memory_sign_extension=1, else zeros. Word is passed unchanged.

Test Plan:
- Store byte: addr=0x1003, data=0xAABBCCDD, ready at once → mem_addr=0x1000, be=4'b1000, wdata=0xDDDDDDDD; done 2 cycles after start.
- Signed load byte: addr=0x2001, rdata=0x0000_8000, sign_ext=1 → load_data=0xFFFFFF80. Unsigned (sign_ext=0) → 0x00000080.
- Load halfword: addr=0x2002, rdata=0x8001_1234 → signed 0xFFFF8001, unsigned 0x00008001. Word load 0xDEADBEEF passes unchanged.
- Misaligned: word at 0x3002, or halfword at 0x3001 → done+misaligned 1 cycle after start; mem_req never asserted.
- Backpressure and timeout: ready held low 3 cycles → request fields stable, done after accept. With MAX_WAIT=4 and ready never high → done+timeout, mem_req low, load_data unchanged.
- Reset in WAIT, then a stray mem_rvalid → stays IDLE, all outputs 0. start pulsed while busy → ignored, exactly one done.
